// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_UREM  = 2'b11;

  // Flag bit positions, identical to the ALU NZCV layout.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // Packs a result and its carry/overflow into the NZCV vector.
  function automatic logic [3:0] md_flags(input logic [31:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = r[31];
    f[FLAG_Z] = (r == 32'd0);
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: 33-bit add (multiply) or
// 33-bit subtract with borrow (restoring divide).
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        i_sub,
  input  logic [32:0] i_x,
  input  logic [31:0] i_y,
  output logic [32:0] o_sum,
  output logic        o_borrow
);

  logic [33:0] w_y;
  logic [33:0] w_full;

  // Extra top bit only carries the sign of a subtract; an add never sets it.
  assign w_y      = i_sub ? ~{2'b00, i_y} : {2'b00, i_y};
  assign w_full   = {1'b0, i_x} + w_y + {33'd0, i_sub};
  assign o_sum    = w_full[32:0];
  assign o_borrow = w_full[33];

endmodule

// File: rtl/muldiv.sv
// Iterative 32-bit unsigned multiply/divide with start/busy/done handshake.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  md_state_t   r_state;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_p;
  logic [31:0] r_res;
  logic [3:0]  r_flags;

  logic        w_is_div;
  logic        w_divz;
  logic        w_last;
  logic [32:0] w_x;
  logic [31:0] w_y;
  logic [32:0] w_sum;
  logic        w_borrow;
  logic [63:0] w_p_next;
  logic [31:0] w_res_next;
  logic [3:0]  w_flags_next;

  assign w_is_div = r_op[1];
  assign w_divz   = w_is_div && (r_b == 32'd0);
  assign w_last   = w_divz || (r_cnt == 5'(MD_ITERS - 1));

  // Multiply adds the multiplicand into the high word; divide trials the
  // shifted remainder (33 bits, since the shift can overflow 32) against b.
  assign w_x = w_is_div ? r_p[63:31] : {1'b0, r_p[63:32]};
  assign w_y = w_is_div ? r_b : r_a;

  muldiv_step u_step (
    .i_sub    (w_is_div),
    .i_x      (w_x),
    .i_y      (w_y),
    .o_sum    (w_sum),
    .o_borrow (w_borrow)
  );

  // Next product / remainder:quotient register for one iteration.
  always_comb begin
    w_p_next = r_p;
    if (w_is_div) begin
      if (w_borrow) w_p_next = {r_p[62:0], 1'b0};
      else          w_p_next = {w_sum[31:0], r_p[30:0], 1'b1};
    end else begin
      if (r_p[0]) w_p_next = {w_sum, r_p[31:1]};
      else        w_p_next = {1'b0, r_p[63:1]};
    end
  end

  // Final result and flags, taken from the register value after the last step.
  always_comb begin
    w_res_next = 32'd0;
    case (r_op)
      OP_MUL:   w_res_next = w_p_next[31:0];
      OP_MULHU: w_res_next = w_p_next[63:32];
      OP_UDIV:  w_res_next = w_divz ? 32'hFFFF_FFFF : w_p_next[31:0];
      OP_UREM:  w_res_next = w_divz ? r_a : w_p_next[63:32];
      default:  w_res_next = 32'd0;
    endcase
    w_flags_next = md_flags(w_res_next,
                            (r_op == OP_MUL) && (w_p_next[63:32] != 32'd0),
                            w_divz);
  end

  // FSM, operand latch, iteration counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= OP_MUL;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_p     <= 64'd0;
      r_res   <= 32'd0;
      r_flags <= 4'b0000;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) begin
            r_res   <= w_res_next;
            r_flags <= w_flags_next;
            r_state <= ST_DONE;
          end
        end
        default: begin
          // IDLE and DONE are both ready; DONE falls back to IDLE unless a
          // new request arrives in the same cycle.
          if (start) begin
            r_state <= ST_RUN;
            r_cnt   <= 5'd0;
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_p     <= op[1] ? {32'd0, a} : {32'd0, b};
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy  = (r_state == ST_RUN);
  assign done  = (r_state == ST_DONE);
  assign res   = r_res;
  assign flags = r_flags;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed cases plus randomized ops
// against a plain-arithmetic reference model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic [3:0]  flags;

  int errs   = 0;
  int checks = 0;

  muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .res   (res),
    .flags (flags)
  );

  always #5 clk = ~clk;

  // Reference: 64-bit arithmetic straight from the operation definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f, output int dc);
    logic [63:0] p;
    logic        c;
    logic        v;
    p = {32'd0, x} * {32'd0, y};
    c = 1'b0;
    v = 1'b0;
    case (o)
      2'b00: begin r = p[31:0]; c = (p[63:32] != 32'd0); end
      2'b01: r = p[63:32];
      2'b10: begin if (y == 0) begin r = 32'hFFFFFFFF; v = 1'b1; end else r = x / y; end
      default: begin if (y == 0) begin r = x; v = 1'b1; end else r = x % y; end
    endcase
    f  = {r[31], (r == 32'd0), c, v};
    dc = (o[1] && y == 0) ? 2 : 33;
  endfunction

  // Issues one op and observes it; dist_cyc>0 perturbs inputs in that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int dist_cyc, input bit dist_start,
                        output logic [31:0] r, output logic [3:0] f, output int done_cyc,
                        output int busy_first, output int busy_last, output int overlap);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    done_cyc = -1; busy_first = -1; busy_last = -1; overlap = 0;
    r = 'x; f = 'x;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (busy && done) overlap = 1;
      if (busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin done_cyc = cyc; r = res; f = flags; end
      start = 1'b0;
      if (cyc == dist_cyc) begin
        start = dist_start; op = 2'($urandom); a = $urandom; b = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    reset = 1'b1; start = 1'b0; op = 2'b00; a = 0; b = 0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0 || flags !== 4'd0) begin
      errs++; $display("FAIL reset_init: busy=%b done=%b res=%h flags=%b expected 0 0 0 0", busy, done, res, flags);
    end
    reset = 1'b0;
    // Load a nonzero result so the mid-run reset has something to clear.
    run_op(2'b10, 32'd5, 32'd0, 0, 1'b0, r, f, dc, bf, bl, ov);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h1234; b = 32'h5678;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL reset_prerun_busy: got %b expected 1", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || res !== 32'd0 || flags !== 4'd0) begin
      errs++; $display("FAIL reset_midrun: busy=%b done=%b res=%h flags=%b expected 0 0 0 0", busy, done, res, flags);
    end
    run_op(2'b00, 32'd3, 32'd4, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd12 || dc != 33) begin
      errs++; $display("FAIL reset_then_mul: res=%h done_cyc=%0d expected 0000000c 33", r, dc);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    run_op(2'b00, 32'd7, 32'd6, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd42 || f !== 4'b0000) begin
      errs++; $display("FAIL mul_7x6: res=%h flags=%b expected 0000002a 0000", r, f);
    end
    checks++; if (bf != 1 || bl != 32 || dc != 33 || ov != 0) begin
      errs++; $display("FAIL mul_timing: busy %0d..%0d done %0d overlap %0d expected 1..32 33 0", bf, bl, dc, ov);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0 || res !== 32'd42) begin
      errs++; $display("FAIL mul_after_done: done=%b busy=%b res=%h expected 0 0 0000002a", done, busy, res);
    end
    run_op(2'b00, 32'h00010000, 32'h00010000, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd0 || f !== 4'b0110) begin
      errs++; $display("FAIL mul_trunc: res=%h flags=%b expected 00000000 0110", r, f);
    end
  endtask

  task automatic test_mulhu();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'hFFFFFFFE || f !== 4'b1000) begin
      errs++; $display("FAIL mulhu_max: res=%h flags=%b expected fffffffe 1000", r, f);
    end
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd1 || f !== 4'b0010) begin
      errs++; $display("FAIL mul_max: res=%h flags=%b expected 00000001 0010", r, f);
    end
  endtask

  task automatic test_div();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    run_op(2'b10, 32'd100, 32'd7, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd14 || f !== 4'b0000 || dc != 33) begin
      errs++; $display("FAIL udiv_100_7: res=%h flags=%b done %0d expected 0000000e 0000 33", r, f, dc);
    end
    run_op(2'b11, 32'd100, 32'd7, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd2 || f !== 4'b0000) begin
      errs++; $display("FAIL urem_100_7: res=%h flags=%b expected 00000002 0000", r, f);
    end
    run_op(2'b10, 32'd5, 32'd9, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd0 || f !== 4'b0100) begin
      errs++; $display("FAIL udiv_5_9: res=%h flags=%b expected 00000000 0100", r, f);
    end
  endtask

  task automatic test_divzero();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    run_op(2'b10, 32'd5, 32'd0, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'hFFFFFFFF || f !== 4'b1001) begin
      errs++; $display("FAIL udiv_by0: res=%h flags=%b expected ffffffff 1001", r, f);
    end
    checks++; if (dc != 2 || bf != 1 || bl != 1 || ov != 0) begin
      errs++; $display("FAIL div0_timing: busy %0d..%0d done %0d expected 1..1 2", bf, bl, dc);
    end
    run_op(2'b11, 32'd5, 32'd0, 0, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd5 || f !== 4'b0001 || dc != 2) begin
      errs++; $display("FAIL urem_by0: res=%h flags=%b done %0d expected 00000005 0001 2", r, f, dc);
    end
  endtask

  task automatic test_handshake();
    logic [31:0] r; logic [3:0] f; int dc, bf, bl, ov;
    run_op(2'b00, 32'd1000, 32'd1000, 5, 1'b1, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd1000000 || dc != 33) begin
      errs++; $display("FAIL start_during_run: res=%h done %0d expected 000f4240 33", r, dc);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL no_queue: busy=%b expected 0", busy); end
    run_op(2'b10, 32'd1000, 32'd3, 3, 1'b0, r, f, dc, bf, bl, ov);
    checks++; if (r !== 32'd333 || dc != 33) begin
      errs++; $display("FAIL inputs_change: res=%h done %0d expected 0000014d 33", r, dc);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2; logic [31:0] r1, r2;
    d1 = -1; d2 = -1; r1 = 'x; r2 = 'x;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    for (int cyc = 1; cyc <= 68; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin d1 = cyc; r1 = res; end
        else if (d2 < 0) begin d2 = cyc; r2 = res; end
      end
      if (cyc == 33) begin op = 2'b10; a = 32'd100; b = 32'd7; end
      if (cyc == 66) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (d1 != 33 || d2 != 66) begin
      errs++; $display("FAIL b2b_timing: done at %0d and %0d expected 33 and 66", d1, d2);
    end
    checks++; if (r1 !== 32'd42 || r2 !== 32'd14) begin
      errs++; $display("FAIL b2b_results: %h %h expected 0000002a 0000000e", r1, r2);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, er, x, y; logic [3:0] f, ef; logic [1:0] o; int dc, edc, bf, bl, ov;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'd0;
      else if ($urandom_range(0, 1) == 1) y = $urandom;
      else y = $urandom_range(1, 300);
      model(o, x, y, er, ef, edc);
      run_op(o, x, y, 0, 1'b0, r, f, dc, bf, bl, ov);
      checks++; if (r !== er || f !== ef || dc != edc || ov != 0) begin
        errs++; $display("FAIL random_%0d op=%0d a=%h b=%h: res=%h flags=%b done %0d expected %h %b %0d",
                         i, o, x, y, r, f, dc, er, ef, edc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_divzero();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
